// File: rtl/pulse_gen_pkg.sv
// Shared definitions for the request-driven pulse train generator:
// FSM state encoding, default parameter values and timing constants.
package pulse_gen_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2,
        S_ACK  = 2'd3
    } state_t;

    localparam int CNT_W_DEFAULT       = 32;
    localparam int N_W_DEFAULT         = 16;
    localparam int SYNC_STAGES_DEFAULT = 2;

    // Shortest gap between pulses; a programmed low time of 0 is stretched to this.
    localparam int MIN_LOW_CYCLES = 1;

endpackage

// File: rtl/bit_sync.sv
// Single-bit N-flop synchronizer with asynchronous active-low reset.
// STAGES = 0 passes the input straight through.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    generate
        if (STAGES == 0) begin : g_bypass
            assign q = d;
        end else begin : g_sync
            logic [STAGES-1:0] sync_p;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_p <= '0;
                end else begin
                    sync_p[0] <= d;
                    for (int i = 1; i < STAGES; i++) begin
                        sync_p[i] <= sync_p[i-1];
                    end
                end
            end

            assign q = sync_p[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/req_pulse_train.sv
// Four-phase req/ack responder: each accepted request emits n_pulses pulses of
// high_cycles high / low_cycles low on pulse_out, then holds ack until req drops.
module req_pulse_train
    import pulse_gen_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int N_W         = N_W_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    output logic             ack,
    input  logic [CNT_W-1:0] high_cycles,
    input  logic [CNT_W-1:0] low_cycles,
    input  logic [N_W-1:0]   n_pulses,
    output logic             pulse_out,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] LOW_MIN = CNT_W'(MIN_LOW_CYCLES);
    localparam logic [N_W-1:0]   REM_ONE = N_W'(1);

    // Reload value for the low phase; low_cycles below the minimum gap is stretched.
    function automatic logic [CNT_W-1:0] low_reload(input logic [CNT_W-1:0] low);
        return (low < LOW_MIN) ? (LOW_MIN - CNT_ONE) : (low - CNT_ONE);
    endfunction

    logic req_s;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0] sh_high_q, sh_high_d;
    logic [CNT_W-1:0] sh_low_q, sh_low_d;
    logic             pulse_q, pulse_d;
    logic             ack_q, ack_d;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (req),
        .q     (req_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            sh_high_q <= '0;
            sh_low_q  <= '0;
            pulse_q   <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            sh_high_q <= sh_high_d;
            sh_low_q  <= sh_low_d;
            pulse_q   <= pulse_d;
            ack_q     <= ack_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        sh_high_d = sh_high_q;
        sh_low_d  = sh_low_q;
        pulse_d   = pulse_q;
        ack_d     = ack_q;

        unique case (state_q)
            S_IDLE: begin
                pulse_d = 1'b0;
                ack_d   = 1'b0;
                if (req_s) begin
                    sh_high_d = high_cycles;
                    sh_low_d  = low_cycles;
                    if ((n_pulses == '0) || (high_cycles == '0)) begin
                        ack_d   = 1'b1;
                        state_d = S_ACK;
                    end else begin
                        pulse_d = 1'b1;
                        cnt_d   = high_cycles - CNT_ONE;
                        rem_d   = n_pulses;
                        state_d = S_HIGH;
                    end
                end
            end

            S_HIGH: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (rem_q == REM_ONE) begin
                    // Last pulse falls on the same edge that ack rises.
                    pulse_d = 1'b0;
                    ack_d   = 1'b1;
                    state_d = S_ACK;
                end else begin
                    rem_d   = rem_q - REM_ONE;
                    pulse_d = 1'b0;
                    cnt_d   = low_reload(sh_low_q);
                    state_d = S_LOW;
                end
            end

            S_LOW: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    pulse_d = 1'b1;
                    cnt_d   = sh_high_q - CNT_ONE;
                    state_d = S_HIGH;
                end
            end

            S_ACK: begin
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ack       = ack_q;
    assign pulse_out = pulse_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_req_pulse_train.sv
// Directed bench for req_pulse_train: a timeline model of the pulse train checked
// every cycle, plus literal per-edge expectations for the key scenarios.
module tb_req_pulse_train;

    localparam int CNT_W = 32;
    localparam int N_W   = 16;
    localparam int SYNC  = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req;
    logic             ack;
    logic [CNT_W-1:0] high_cycles;
    logic [CNT_W-1:0] low_cycles;
    logic [N_W-1:0]   n_pulses;
    logic             pulse_out;
    logic             busy;

    int checks = 0;
    int errors = 0;

    req_pulse_train #(
        .CNT_W       (CNT_W),
        .N_W         (N_W),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .ack         (ack),
        .high_cycles (high_cycles),
        .low_cycles  (low_cycles),
        .n_pulses    (n_pulses),
        .pulse_out   (pulse_out),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: once a request is accepted at edge A, pulse k occupies
    // edges A + k*(H+Lp) .. +H-1, and the train ends at A + N*H + (N-1)*Lp.
    int      m_mode;            // 0 idle, 1 train, 2 ack
    longint  m_edge;
    longint  m_start, m_end, m_h, m_per;
    bit [3:0] m_hist;
    logic    exp_pulse, exp_ack, exp_busy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode    <= 0;
            m_edge    <= 0;
            m_start   <= 0;
            m_end     <= 0;
            m_h       <= 0;
            m_per     <= 0;
            m_hist    <= '0;
            exp_pulse <= 1'b0;
            exp_ack   <= 1'b0;
            exp_busy  <= 1'b0;
        end else begin
            automatic bit [4:0] hv   = {m_hist, req};
            automatic bit       rs   = hv[SYNC];
            automatic longint   e    = m_edge + 1;
            automatic int       mode = m_mode;
            automatic longint   st   = m_start;
            automatic longint   en   = m_end;
            automatic longint   h    = m_h;
            automatic longint   per  = m_per;
            case (m_mode)
                0: if (rs) begin
                    if (n_pulses == 0 || high_cycles == 0) begin
                        mode = 2;
                    end else begin
                        automatic longint lp = (low_cycles == 0) ? 1 : longint'(low_cycles);
                        h    = longint'(high_cycles);
                        per  = h + lp;
                        st   = e;
                        en   = e + longint'(n_pulses) * h + (longint'(n_pulses) - 1) * lp;
                        mode = 1;
                    end
                end
                1: if (e == m_end) mode = 2;
                default: if (!rs) mode = 0;
            endcase
            m_hist    <= hv[3:0];
            m_edge    <= e;
            m_mode    <= mode;
            m_start   <= st;
            m_end     <= en;
            m_h       <= h;
            m_per     <= per;
            exp_pulse <= (mode == 1) && (((e - st) % per) < h);
            exp_ack   <= (mode == 2);
            exp_busy  <= (mode != 0);
        end
    end

    always @(negedge clk) begin
        check("model_pulse_out", 32'(pulse_out), 32'(exp_pulse));
        check("model_ack", 32'(ack), 32'(exp_ack));
        check("model_busy", 32'(busy), 32'(exp_busy));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for ack to reach a level, counting pulse_out rising edges seen.
    task automatic wait_ack(input logic lvl, input int budget, input string name, output int pulses);
        int k = 0;
        logic prev = pulse_out;
        pulses = 0;
        while (ack !== lvl && k < budget) begin
            tick();
            if (pulse_out && !prev) pulses++;
            prev = pulse_out;
            k++;
        end
        check(name, 32'(ack), 32'(lvl));
    endtask

    task automatic setup(input int h, input int l, input int n);
        high_cycles = CNT_W'(h);
        low_cycles  = CNT_W'(l);
        n_pulses    = N_W'(n);
    endtask

    task automatic release_and_idle(input string name);
        int dummy;
        req = 1'b0;
        wait_ack(1'b0, 20, name, dummy);
        tick();
        check({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int np;
        rst_n = 1'b0;
        req   = 1'b1;
        setup(3, 2, 3);

        // Reset held with req high
        repeat (3) tick();
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_pulse", 32'(pulse_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("rst_release_busy", 32'(busy), 32'(k == 3));
        end
        wait_ack(1'b1, 40, "rst_train_ack", np);
        release_and_idle("rst_train_idle");

        // Nominal train, req raised just after edge 0
        setup(3, 2, 3);
        tick();
        req = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            tick();
            check("nom_pulse", 32'(pulse_out),
                  32'((k >= 3 && k <= 5) || (k >= 8 && k <= 10) || (k >= 13 && k <= 15)));
            check("nom_ack", 32'(ack), 32'(k >= 16 && k <= 22));
            check("nom_busy", 32'(busy), 32'(k >= 3 && k <= 22));
            if (k == 20) req = 1'b0;
        end

        // Zero-work requests: n_pulses = 0, then high_cycles = 0
        for (int z = 0; z < 2; z++) begin
            if (z == 0) setup(3, 2, 0);
            else        setup(0, 2, 3);
            tick();
            req = 1'b1;
            for (int k = 1; k <= 5; k++) begin
                tick();
                check("zero_pulse", 32'(pulse_out), 32'd0);
                check("zero_ack", 32'(ack), 32'(k >= 3));
            end
            release_and_idle("zero_idle");
        end

        // Minimum low time: 1,0,1 then ack
        setup(1, 0, 2);
        tick();
        req = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check("minlow_pulse", 32'(pulse_out), 32'(k == 3 || k == 5));
            check("minlow_ack", 32'(ack), 32'(k >= 6));
        end
        release_and_idle("minlow_idle");

        // Shadowing: high_cycles changes mid-train, remaining pulses stay 3 wide
        setup(3, 2, 3);
        tick();
        req = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 6) high_cycles = CNT_W'(7);
            check("shadow_pulse", 32'(pulse_out),
                  32'((k >= 3 && k <= 5) || (k >= 8 && k <= 10) || (k >= 13 && k <= 15)));
            check("shadow_ack", 32'(ack), 32'(k == 16));
        end
        release_and_idle("shadow_idle");

        // Reset asserted mid-pulse, then a fresh full train
        setup(3, 2, 3);
        tick();
        req = 1'b1;
        repeat (4) tick();
        check("midrst_pre_pulse", 32'(pulse_out), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_pulse", 32'(pulse_out), 32'd0);
        check("midrst_ack", 32'(ack), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        wait_ack(1'b1, 40, "midrst_train_ack", np);
        check("midrst_train_pulses", 32'(np), 32'd3);
        release_and_idle("midrst_idle");

        // Back-to-back handshakes as an upstream edge-triggered requester would issue
        setup(2, 3, 4);
        for (int t = 0; t < 2; t++) begin
            int start_t;
            start_t = int'($time);
            req = 1'b1;
            wait_ack(1'b1, 40, "b2b_ack_rise", np);
            check("b2b_pulses", 32'(np), 32'd4);
            release_and_idle("b2b_idle");
            while (int'($time) - start_t < 400) tick();
        end

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/req_pulse_train.md
Name: req_pulse_train

Overview:
- Four-phase request/acknowledge responder that sits directly downstream of pedge_req.
- On each accepted req it emits a programmable train of pulses on pulse_out: n_pulses pulses, each high_cycles high and low_cycles low between pulses.
- It then raises ack and holds it until req is released, completing the handshake the upstream requester waits on (ack high, then ack falling edge).

Parameters:
- CNT_W, 32, width of high_cycles, low_cycles and the internal phase counter.
- N_W, 16, width of n_pulses and the internal remaining-pulse counter.
- SYNC_STAGES, 2, flops on the req input (0 = no synchronizer; legal range 0..3).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- req  input  1  handshake request (level), four-phase protocol.
- ack  output  1  handshake acknowledge, registered.
- high_cycles  input  CNT_W  pulse high time in clk cycles.
- low_cycles  input  CNT_W  inter-pulse low time in clk cycles.
- n_pulses  input  N_W  number of pulses per request.
- pulse_out  output  1  pulse train output, registered, glitch-free.
- busy  output  1  high whenever the FSM is not in S_IDLE.

Behaviour:
- Reset (rst_n low, any time, including mid-train):
  - ack, pulse_out and busy go to 0; FSM goes to S_IDLE.
  - Counters, shadow registers and synchronizer flops clear to 0.
- Synchronizer: req_s is req delayed by SYNC_STAGES flops. All FSM decisions use req_s.
- S_IDLE, req_s low: stay in S_IDLE, ack = 0, pulse_out = 0.
- S_IDLE, req_s high:
  - Capture high_cycles, low_cycles and n_pulses into shadow registers. Later input changes are ignored until the next S_IDLE.
  - If n_pulses == 0 or high_cycles == 0: set ack = 1 and go to S_ACK. No pulse is emitted.
  - Otherwise: set pulse_out = 1, phase counter = high_cycles-1, remaining = n_pulses, and go to S_HIGH.
- Latency: first pulse_out rise occurs SYNC_STAGES+1 clk edges after req is first sampled high.
- S_HIGH, phase counter != 0: decrement the counter. pulse_out stays high for exactly high_cycles cycles.
- S_HIGH, phase counter == 0:
  - If remaining == 1: pulse_out = 0, ack = 1, go to S_ACK. ack rises on the same edge as the last pulse falls.
  - Otherwise: decrement remaining, pulse_out = 0, phase counter = max(low_cycles,1)-1, go to S_LOW.
  - low_cycles == 0 is treated as 1 so that pulses never merge.
- S_LOW, phase counter != 0: decrement the counter.
- S_LOW, phase counter == 0: pulse_out = 1, phase counter = high_cycles-1, go to S_HIGH.
- S_ACK: hold ack = 1 while req_s is high. When req_s is low, set ack = 0 and go to S_IDLE.
  - ack is therefore high for at least one cycle even if req was released early.
- A new request is accepted only from S_IDLE, and only after ack has been low for at least one cycle.
- req falling during S_HIGH or S_LOW is a protocol violation by the requester. The train still completes, then ack pulses for one cycle.
- Counters are unsigned with no wrap-around: high_cycles = 2^CNT_W-1 is legal and is counted exactly.

Decomposition:
- Shared package pulse_gen_pkg holds:
  - state encodings S_IDLE, S_HIGH, S_LOW, S_ACK;
  - default parameter constants;
  - the minimum-low-time constant (1).
- One sub-module, bit_sync: a parameterised N-flop single-bit synchronizer with async active-low reset, used for req.

Test Plan:
- Reset: hold rst_n low with req = 1 → ack = 0, pulse_out = 0, busy = 0. After release with SYNC_STAGES = 2, busy rises 3 cycles later.
- Nominal train: high = 3, low = 2, n = 3, req raised at edge 0.
  - pulse_out is high for edges 3-5, 8-10 and 13-15, low otherwise; ack rises at edge 16.
  - req dropped at edge 20 → ack falls at edge 23 and busy falls at edge 23.
- Zero-work request: n_pulses = 0 (and separately high_cycles = 0) → pulse_out never rises; ack rises at edge 3.
- Minimum low: high = 1, low = 0, n = 2 → pulse_out pattern is 1,0,1 on consecutive cycles, then ack.
- Shadowing and reset: change high_cycles from 3 to 7 mid-train → the remaining pulses stay 3 wide. Asserting rst_n low mid-pulse → pulse_out and ack go low immediately; the next request produces a full train.
- Back-to-back with pedge_req upstream:
  - Two rising edges on its input, 40 cycles apart, produce two complete trains.
  - Each ack falling edge returns the requester to idle.
  - No overlapping trains.
